// File: rtl/vip_stream_top.sv
//==============================================================================
// Module      : vip_stream_top
// Description : Pixel stream block: input FIFO -> 3-stage pixel pipeline -> output FIFO
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module vip_stream_top #(
  parameter int CH_WIDTH = 8,
  parameter int IN_AW    = 4,
  parameter int OUT_AW   = 4
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [3*CH_WIDTH-1:0]   fifo_in_data,
  input  logic                    fifo_in_wrreq,
  output logic                    fifo_in_full,
  output logic [IN_AW:0]          fifo_in_usedw,
  output logic [3*CH_WIDTH-1:0]   fifo_out_data,
  input  logic                    fifo_out_rdreq,
  output logic                    fifo_out_empty,
  output logic [OUT_AW:0]         fifo_out_usedw,
  input  logic [1:0]              mode,
  input  logic                    clear_flags,
  output logic                    overflow,
  output logic                    underflow
);

  localparam int c_DWIDTH = 3 * CH_WIDTH;
  localparam int c_PW     = CH_WIDTH + 10;
  localparam int c_IN_DEPTH  = 1 << IN_AW;
  localparam int c_OUT_DEPTH = 1 << OUT_AW;
  localparam logic [IN_AW:0]    c_IN_FULL   = {1'b1, {IN_AW{1'b0}}};
  localparam logic [OUT_AW+1:0] c_OUT_LIMIT = {2'b01, {OUT_AW{1'b0}}};
  localparam logic [1:0] c_MODE_INV  = 2'd1;
  localparam logic [1:0] c_MODE_GRAY = 2'd2;
  localparam logic [c_PW-1:0] c_COEF_R = c_PW'(77);
  localparam logic [c_PW-1:0] c_COEF_G = c_PW'(150);
  localparam logic [c_PW-1:0] c_COEF_B = c_PW'(29);

  // ---------------- input FIFO ----------------
  logic [c_DWIDTH-1:0] r_in_mem [c_IN_DEPTH];
  logic [IN_AW-1:0]    r_in_wptr;
  logic [IN_AW-1:0]    r_in_rptr;
  logic [IN_AW:0]      r_in_cnt;
  logic                w_in_full;
  logic                w_in_wr;
  logic                w_pop;

  // ---------------- pipeline ----------------
  logic                r_s0_v, r_s1_v, r_s2_v;
  logic [c_DWIDTH-1:0] r_s0_data, r_s1_data, r_s2_data;
  logic [1:0]          r_s0_mode, r_s1_mode;
  logic [c_PW-1:0]     r_s1_pr, r_s1_pg, r_s1_pb;
  logic [c_PW-1:0]     w_sum;
  logic [CH_WIDTH-1:0] w_y;
  logic [c_DWIDTH-1:0] w_s2_next;
  logic [OUT_AW+1:0]   w_out_occ;

  // ---------------- output FIFO ----------------
  logic [c_DWIDTH-1:0] r_out_mem [c_OUT_DEPTH];
  logic [OUT_AW-1:0]   r_out_wptr;
  logic [OUT_AW-1:0]   r_out_rptr;
  logic [OUT_AW:0]     r_out_cnt;
  logic [c_DWIDTH-1:0] r_out_data;
  logic                w_out_empty;
  logic                w_out_rd;
  logic                r_overflow;
  logic                r_underflow;

  assign w_in_full   = (r_in_cnt == c_IN_FULL);
  assign w_in_wr     = fifo_in_wrreq & ~w_in_full;
  assign w_out_empty = (r_out_cnt == '0);
  assign w_out_rd    = fifo_out_rdreq & ~w_out_empty;

  // Words already in the pipeline count against output space, so the output FIFO never overflows.
  assign w_out_occ = {1'b0, r_out_cnt} + {{(OUT_AW+1){1'b0}}, r_s0_v}
                   + {{(OUT_AW+1){1'b0}}, r_s1_v} + {{(OUT_AW+1){1'b0}}, r_s2_v};
  assign w_pop     = (r_in_cnt != '0) && (w_out_occ < c_OUT_LIMIT);

  always_ff @(posedge clock) begin
    if (w_in_wr) r_in_mem[r_in_wptr] <= fifo_in_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_in_wptr <= '0;
      r_in_rptr <= '0;
      r_in_cnt  <= '0;
    end else begin
      if (w_in_wr) r_in_wptr <= r_in_wptr + IN_AW'(1);
      if (w_pop)   r_in_rptr <= r_in_rptr + IN_AW'(1);
      case ({w_in_wr, w_pop})
        2'b10:   r_in_cnt <= r_in_cnt + (IN_AW+1)'(1);
        2'b01:   r_in_cnt <= r_in_cnt - (IN_AW+1)'(1);
        default: r_in_cnt <= r_in_cnt;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_s0_v <= 1'b0;
      r_s1_v <= 1'b0;
      r_s2_v <= 1'b0;
    end else begin
      r_s0_v <= w_pop;
      r_s1_v <= r_s0_v;
      r_s2_v <= r_s1_v;
    end
  end

  // Mode is captured at pop and carried along so later mode changes leave this word alone.
  always_ff @(posedge clock) begin
    if (w_pop) begin
      r_s0_data <= r_in_mem[r_in_rptr];
      r_s0_mode <= mode;
    end
    r_s1_data <= r_s0_data;
    r_s1_mode <= r_s0_mode;
    r_s1_pr   <= c_COEF_R * {{10{1'b0}}, r_s0_data[3*CH_WIDTH-1:2*CH_WIDTH]};
    r_s1_pg   <= c_COEF_G * {{10{1'b0}}, r_s0_data[2*CH_WIDTH-1:CH_WIDTH]};
    r_s1_pb   <= c_COEF_B * {{10{1'b0}}, r_s0_data[CH_WIDTH-1:0]};
    r_s2_data <= w_s2_next;
  end

  assign w_sum = r_s1_pr + r_s1_pg + r_s1_pb;
  assign w_y   = CH_WIDTH'(w_sum >> 8);

  always_comb begin
    w_s2_next = r_s1_data;
    case (r_s1_mode)
      c_MODE_INV:  w_s2_next = ~r_s1_data;
      c_MODE_GRAY: w_s2_next = {w_y, w_y, w_y};
      default:     w_s2_next = r_s1_data;
    endcase
  end

  always_ff @(posedge clock) begin
    if (r_s2_v) r_out_mem[r_out_wptr] <= r_s2_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_wptr <= '0;
      r_out_rptr <= '0;
      r_out_cnt  <= '0;
      r_out_data <= '0;
    end else begin
      if (r_s2_v) r_out_wptr <= r_out_wptr + OUT_AW'(1);
      if (w_out_rd) begin
        r_out_rptr <= r_out_rptr + OUT_AW'(1);
        r_out_data <= r_out_mem[r_out_rptr];
      end
      case ({r_s2_v, w_out_rd})
        2'b10:   r_out_cnt <= r_out_cnt + (OUT_AW+1)'(1);
        2'b01:   r_out_cnt <= r_out_cnt - (OUT_AW+1)'(1);
        default: r_out_cnt <= r_out_cnt;
      endcase
    end
  end

  // A new error event wins over a simultaneous clear.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_overflow  <= (fifo_in_wrreq & w_in_full) | (r_overflow & ~clear_flags);
      r_underflow <= (fifo_out_rdreq & w_out_empty) | (r_underflow & ~clear_flags);
    end
  end

  assign fifo_in_full   = w_in_full;
  assign fifo_in_usedw  = r_in_cnt;
  assign fifo_out_data  = r_out_data;
  assign fifo_out_empty = w_out_empty;
  assign fifo_out_usedw = r_out_cnt;
  assign overflow       = r_overflow;
  assign underflow      = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_vip_stream_top.sv
//==============================================================================
// Module      : tb_vip_stream_top
// Description : Directed and randomized checks of vip_stream_top against a queue model
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_vip_stream_top;

  logic        clock = 1'b0;
  logic        reset;
  logic [23:0] fifo_in_data;
  logic        fifo_in_wrreq;
  logic        fifo_in_full;
  logic [4:0]  fifo_in_usedw;
  logic [23:0] fifo_out_data;
  logic        fifo_out_rdreq;
  logic        fifo_out_empty;
  logic [4:0]  fifo_out_usedw;
  logic [1:0]  mode;
  logic        clear_flags;
  logic        overflow;
  logic        underflow;

  vip_stream_top #(.CH_WIDTH(8), .IN_AW(4), .OUT_AW(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .fifo_in_data   (fifo_in_data),
    .fifo_in_wrreq  (fifo_in_wrreq),
    .fifo_in_full   (fifo_in_full),
    .fifo_in_usedw  (fifo_in_usedw),
    .fifo_out_data  (fifo_out_data),
    .fifo_out_rdreq (fifo_out_rdreq),
    .fifo_out_empty (fifo_out_empty),
    .fifo_out_usedw (fifo_out_usedw),
    .mode           (mode),
    .clear_flags    (clear_flags),
    .overflow       (overflow),
    .underflow      (underflow)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [23:0] raw;
    int          avail;   // edge after which the word sits in the output FIFO
  } ent_t;

  int          total = 0;
  int          bad   = 0;
  int          cyc   = 0;
  ent_t        q[$];
  logic [1:0]  mode_hist [0:16383];
  logic [23:0] vin  [0:4];
  logic [23:0] vexp [0:4];
  logic [23:0] t3w  [0:32];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    cyc++;
    #1;
  endtask

  function automatic logic [23:0] ref_px(input logic [23:0] p, input logic [1:0] m);
    int r, g, b, y;
    r = int'(p[23:16]);
    g = int'(p[15:8]);
    b = int'(p[7:0]);
    case (m)
      2'd1: return {8'(255 - r), 8'(255 - g), 8'(255 - b)};
      2'd2: begin
        y = (77 * r + 150 * g + 29 * b) / 256;
        return {8'(y), 8'(y), 8'(y)};
      end
      default: return p;
    endcase
  endfunction

  // Write n words back to back, check first-word latency, then read them out.
  task automatic group(input logic [1:0] m, input int n, input string tag);
    mode = m;
    for (int k = 0; k < 5; k++) begin
      fifo_in_wrreq = (k < n);
      fifo_in_data  = vin[k];
      tick();
      if (k == 3) chk({tag, "_empty_n3"}, {31'd0, fifo_out_empty}, 32'd1);
      if (k == 4) chk({tag, "_empty_n4"}, {31'd0, fifo_out_empty}, 32'd0);
    end
    fifo_in_wrreq = 1'b0;
    for (int i = 0; i < n; i++) begin
      fifo_out_rdreq = 1'b1;
      tick();
      chk({tag, "_data"}, {8'd0, fifo_out_data}, {8'd0, vexp[i]});
    end
    fifo_out_rdreq = 1'b0;
    tick();
    chk({tag, "_drained"}, {31'd0, fifo_out_empty}, 32'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          e, cnt_in, cnt_out;
    logic        w, rd, clr, uf, ov, uf_set;
    logic [1:0]  m;
    logic [23:0] d, exp_data;
    ent_t        ent;

    reset = 1'b1; fifo_in_data = '0; fifo_in_wrreq = 1'b0; fifo_out_rdreq = 1'b0;
    mode = 2'd0; clear_flags = 1'b0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_full",   {31'd0, fifo_in_full},   32'd0);
    chk("rst_usedw_in",  {27'd0, fifo_in_usedw},  32'd0);
    chk("rst_empty",  {31'd0, fifo_out_empty}, 32'd1);
    chk("rst_usedw_out", {27'd0, fifo_out_usedw}, 32'd0);
    chk("rst_data",   {8'd0, fifo_out_data},   32'd0);
    chk("rst_flags",  {30'd0, overflow, underflow}, 32'd0);

    // Known-answer vectors
    vin[0] = 24'h123456; vin[1] = 24'hABCDEF;
    vexp[0] = 24'h123456; vexp[1] = 24'hABCDEF;
    group(2'd0, 2, "t1_bypass");
    vin[0] = 24'h123456; vexp[0] = 24'hEDCBA9;
    group(2'd1, 1, "t2_invert");
    vin[0] = 24'hFF0000; vin[1] = 24'h000000; vin[2] = 24'hFFFFFF;
    vexp[0] = 24'h4C4C4C; vexp[1] = 24'h000000; vexp[2] = 24'hFFFFFF;
    group(2'd2, 3, "t2_gray");

    // Underflow and flag clearing
    fifo_out_rdreq = 1'b1; tick();
    chk("t4_underflow_set", {31'd0, underflow}, 32'd1);
    chk("t4_data_held", {8'd0, fifo_out_data}, 32'h00FFFFFF);
    fifo_out_rdreq = 1'b0; clear_flags = 1'b1; tick();
    chk("t4_underflow_clr", {31'd0, underflow}, 32'd0);
    fifo_out_rdreq = 1'b1; tick();
    chk("t4_set_beats_clr", {31'd0, underflow}, 32'd1);
    chk("t4_overflow_quiet", {31'd0, overflow}, 32'd0);
    fifo_out_rdreq = 1'b0; tick();
    clear_flags = 1'b0;

    // Fill both FIFOs, overflow on the 33rd word, then drain
    mode = 2'd0;
    for (int i = 0; i < 33; i++) begin
      t3w[i] = 24'($urandom);
      fifo_in_wrreq = 1'b1;
      fifo_in_data  = t3w[i];
      tick();
      if (i == 31) begin
        chk("t3_full_at_32", {31'd0, fifo_in_full}, 32'd1);
        chk("t3_no_ovf_at_32", {31'd0, overflow}, 32'd0);
      end
      if (i == 32) chk("t3_ovf_at_33", {31'd0, overflow}, 32'd1);
    end
    fifo_in_wrreq = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    chk("t3_usedw_in",  {27'd0, fifo_in_usedw},  32'd16);
    chk("t3_usedw_out", {27'd0, fifo_out_usedw}, 32'd16);
    chk("t3_full",      {31'd0, fifo_in_full},   32'd1);
    for (int i = 0; i < 32; i++) begin
      fifo_out_rdreq = 1'b1;
      tick();
      chk("t3_drain_data", {8'd0, fifo_out_data}, {8'd0, t3w[i]});
    end
    fifo_out_rdreq = 1'b0;
    chk("t3_empty_after", {31'd0, fifo_out_empty}, 32'd1);
    chk("t3_no_underflow", {31'd0, underflow}, 32'd0);
    chk("t3_usedw_zero", {22'd0, fifo_in_usedw, fifo_out_usedw}, 32'd0);

    // Reset while words are stored and in flight
    for (int i = 0; i < 10; i++) begin
      fifo_in_wrreq  = 1'b1;
      fifo_in_data   = 24'($urandom);
      fifo_out_rdreq = (i == 0);
      tick();
    end
    fifo_in_wrreq = 1'b0; fifo_out_rdreq = 1'b0;
    chk("t6_pre_flags", {30'd0, overflow, underflow}, 32'd3);
    reset = 1'b1; tick(); reset = 1'b0;
    chk("t6_empty", {31'd0, fifo_out_empty}, 32'd1);
    chk("t6_usedw", {22'd0, fifo_in_usedw, fifo_out_usedw}, 32'd0);
    chk("t6_flags", {30'd0, overflow, underflow}, 32'd0);
    chk("t6_data",  {8'd0, fifo_out_data}, 32'd0);
    chk("t6_full",  {31'd0, fifo_in_full}, 32'd0);
    fifo_in_wrreq = 1'b1; fifo_in_data = 24'h00A5C3; tick();
    fifo_in_wrreq = 1'b0;
    chk("t6_after_usedw_in", {27'd0, fifo_in_usedw}, 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("t6_after_usedw_out", {27'd0, fifo_out_usedw}, 32'd1);
    fifo_out_rdreq = 1'b1; tick(); fifo_out_rdreq = 1'b0;
    chk("t6_after_data", {8'd0, fifo_out_data}, 32'h0000A5C3);

    // Randomized streaming with per-cycle mode changes against the queue model
    reset = 1'b1; tick(); reset = 1'b0;
    q.delete();
    uf = 1'b0; ov = 1'b0; exp_data = '0;
    for (int it = 0; it < 3000; it++) begin
      e   = cyc + 1;
      w   = (q.size() < 16) && ($urandom_range(0, 99) < 60);
      rd  = ($urandom_range(0, 99) < 45);
      clr = ($urandom_range(0, 99) < 4);
      m   = 2'($urandom_range(0, 3));
      d   = 24'($urandom);
      fifo_in_wrreq = w; fifo_in_data = d; fifo_out_rdreq = rd;
      clear_flags = clr; mode = m;
      mode_hist[e] = m;

      uf_set = 1'b0;
      if (rd) begin
        if (q.size() > 0 && q[0].avail < e) begin
          ent = q.pop_front();
          exp_data = ref_px(ent.raw, mode_hist[ent.avail - 3]);
        end else begin
          uf_set = 1'b1;
        end
      end
      uf = uf_set | (uf & ~clr);
      ov = ov & ~clr;
      if (w) begin
        ent.raw = d; ent.avail = e + 4;
        q.push_back(ent);
      end

      tick();
      cnt_in = 0; cnt_out = 0;
      foreach (q[j]) begin
        if (q[j].avail <= e) cnt_out++;
        if (q[j].avail - 3 > e) cnt_in++;
      end
      chk("rnd_data",      {8'd0, fifo_out_data}, {8'd0, exp_data});
      chk("rnd_empty",     {31'd0, fifo_out_empty}, {31'd0, cnt_out == 0});
      chk("rnd_usedw_out", {27'd0, fifo_out_usedw}, 32'(cnt_out));
      chk("rnd_usedw_in",  {27'd0, fifo_in_usedw},  32'(cnt_in));
      chk("rnd_full",      {31'd0, fifo_in_full}, 32'd0);
      chk("rnd_flags",     {30'd0, overflow, underflow}, {30'd0, ov, uf});
    end
    fifo_in_wrreq = 1'b0; fifo_out_rdreq = 1'b0; clear_flags = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
